// File: rtl/mcbsp_sched_pkg.sv
// Shared types and constants for the McBSP slave transmit scheduler.
package mcbsp_sched_pkg;

    typedef enum logic [2:0] {StIdle, StArb, StHdr, StData, StTail} sched_state_e;

    localparam logic [7:0]  HDR_TAG   = 8'hA5;
    localparam logic [31:0] TAIL_WORD = 32'hE0D0_E0D0;

    localparam int unsigned LOAD_CNT = 2;
    localparam int unsigned FSX_CNT  = 3;
    localparam int unsigned BIT0_CNT = 4;

    // Header layout: tag, 6 zero bits, channel, 5 zero bits, payload length.
    function automatic logic [31:0] hdr_word(input logic [1:0] ch, input logic [10:0] len);
        return {HDR_TAG, 6'd0, ch, 5'd0, len};
    endfunction

endpackage

// File: rtl/mcbsp_word_serializer.sv
// Slot counter and 32-bit MSB-first shifter producing one framed word per slot.
module mcbsp_word_serializer
    import mcbsp_sched_pkg::*;
#(
    parameter int unsigned SLOT_LEN = 36
) (
    input  logic        cfg_spi_clk,
    input  logic        cfg_spi_rst_n,
    input  logic        run,
    input  logic [31:0] word,
    output logic        slot_end,
    output logic        fsx,
    output logic        mosi
);

    localparam int unsigned     CW       = $clog2(SLOT_LEN);
    localparam logic [CW-1:0]   LAST_CNT = CW'(SLOT_LEN - 1);

    logic [CW-1:0] cnt_q;
    logic [31:0]   shreg_q;

    assign slot_end = run && (cnt_q == LAST_CNT);

    // Outputs are registered, so each is set on the edge leaving the previous count.
    always_ff @(posedge cfg_spi_clk or negedge cfg_spi_rst_n) begin
        if (!cfg_spi_rst_n) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            fsx     <= 1'b0;
            mosi    <= 1'b0;
        end else if (!run) begin
            cnt_q <= '0;
            fsx   <= 1'b0;
            mosi  <= 1'b0;
        end else begin
            cnt_q <= slot_end ? '0 : cnt_q + CW'(1);
            fsx   <= (cnt_q == CW'(FSX_CNT - 1));
            if (cnt_q == CW'(LOAD_CNT)) begin
                shreg_q <= word;
                mosi    <= 1'b0;
            end else if (cnt_q >= CW'(BIT0_CNT - 1) && cnt_q < LAST_CNT) begin
                mosi    <= shreg_q[31];
                shreg_q <= {shreg_q[30:0], 1'b0};
            end else begin
                mosi <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mcbsp_slaver_scheduler.sv
// Round-robin burst scheduler for the McBSP slave link: header, ROM payload, tail per grant.
module mcbsp_slaver_scheduler
    import mcbsp_sched_pkg::*;
#(
    parameter int unsigned SLOT_LEN = 36,
    parameter int unsigned AW       = 11,
    parameter int unsigned NCH      = 4
) (
    input  logic              cfg_spi_clk,
    input  logic              cfg_spi_rst_n,
    input  logic              slot_start,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH*AW-1:0] ch_base,
    input  logic [NCH*AW-1:0] ch_len,
    output logic [NCH-1:0]    ch_grant,
    output logic [NCH-1:0]    ch_done,
    output logic [AW-1:0]     src_addr,
    input  logic [31:0]       src_data,
    output logic              mcbsp_slaver_clkx,
    output logic              mcbsp_slaver_fsx,
    output logic              mcbsp_slaver_mosi,
    output logic              busy,
    output logic              slot_overrun
);

    localparam int unsigned CHW = $clog2(NCH);

    sched_state_e   state_q;
    logic           armed_q;
    logic [CHW-1:0] last_q;
    logic [CHW-1:0] ch_q;
    logic [AW-1:0]  base_q;
    logic [AW-1:0]  len_q;
    logic [AW-1:0]  rem_q;

    logic           win_found;
    logic [CHW-1:0] win_ch;
    logic [CHW-1:0] idx;
    logic           run;
    logic           slot_end;
    logic [31:0]    word;

    assign mcbsp_slaver_clkx = cfg_spi_clk;
    assign busy = (state_q != StIdle);
    assign run  = (state_q == StHdr) || (state_q == StData) || (state_q == StTail);

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_ch    = '0;
        idx       = '0;
        for (int i = 1; i <= int'(NCH); i++) begin
            idx = CHW'(int'(last_q) + i);
            if (!win_found && ch_req[idx]) begin
                win_found = 1'b1;
                win_ch    = idx;
            end
        end
    end

    always_comb begin
        word = TAIL_WORD;
        case (state_q)
            StHdr:   word = hdr_word(ch_q, 11'(len_q));
            StData:  word = src_data;
            default: ;
        endcase
    end

    always_ff @(posedge cfg_spi_clk or negedge cfg_spi_rst_n) begin
        if (!cfg_spi_rst_n) begin
            state_q      <= StIdle;
            armed_q      <= 1'b0;
            last_q       <= CHW'(NCH - 1);
            ch_q         <= '0;
            base_q       <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            ch_grant     <= '0;
            ch_done      <= '0;
            src_addr     <= '0;
            slot_overrun <= 1'b0;
        end else begin
            ch_done      <= '0;
            slot_overrun <= slot_start && armed_q;
            if (slot_start) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if ((armed_q || slot_start) && (|ch_req)) begin
                        state_q <= StArb;
                    end
                end
                StArb: begin
                    if (win_found) begin
                        ch_q     <= win_ch;
                        last_q   <= win_ch;
                        base_q   <= ch_base[int'(win_ch)*AW +: AW];
                        len_q    <= ch_len[int'(win_ch)*AW +: AW];
                        ch_grant <= NCH'(1) << win_ch;
                        state_q  <= StHdr;
                    end else begin
                        if (!slot_start) begin
                            armed_q <= 1'b0;
                        end
                        state_q <= StIdle;
                    end
                end
                StHdr: begin
                    if (slot_end) begin
                        src_addr <= base_q;
                        rem_q    <= len_q;
                        state_q  <= (len_q == '0) ? StTail : StData;
                    end
                end
                StData: begin
                    if (slot_end) begin
                        rem_q <= rem_q - AW'(1);
                        if (rem_q == AW'(1)) begin
                            state_q <= StTail;
                        end else begin
                            src_addr <= src_addr + AW'(1);
                        end
                    end
                end
                StTail: begin
                    if (slot_end) begin
                        ch_done  <= ch_grant;
                        ch_grant <= '0;
                        state_q  <= StArb;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    mcbsp_word_serializer #(
        .SLOT_LEN (SLOT_LEN)
    ) u_serializer (
        .cfg_spi_clk   (cfg_spi_clk),
        .cfg_spi_rst_n (cfg_spi_rst_n),
        .run           (run),
        .word          (word),
        .slot_end      (slot_end),
        .fsx           (mcbsp_slaver_fsx),
        .mosi          (mcbsp_slaver_mosi)
    );

endmodule

// File: tb/tb_mcbsp_slaver_scheduler.sv
// Directed scoreboard bench for mcbsp_slaver_scheduler: serial words checked against a queue.
module tb_mcbsp_slaver_scheduler;

    localparam int unsigned AW = 11;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            slot_start = 1'b0;
    logic [3:0]      ch_req = '0;
    logic [4*AW-1:0] ch_base = '0;
    logic [4*AW-1:0] ch_len = '0;
    logic [3:0]      ch_grant;
    logic [3:0]      ch_done;
    logic [AW-1:0]   src_addr;
    logic [31:0]     src_data = '0;
    logic            clkx;
    logic            fsx;
    logic            mosi;
    logic            busy;
    logic            slot_overrun;

    typedef struct {
        logic [31:0] word;
        int          gap;
        logic [3:0]  grant;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt [4] = '{0, 0, 0, 0};
    int   ovr_cnt = 0;
    int   act;

    mcbsp_slaver_scheduler #(
        .SLOT_LEN (36),
        .AW       (AW),
        .NCH      (4)
    ) dut (
        .cfg_spi_clk       (clk),
        .cfg_spi_rst_n     (rst_n),
        .slot_start        (slot_start),
        .ch_req            (ch_req),
        .ch_base           (ch_base),
        .ch_len            (ch_len),
        .ch_grant          (ch_grant),
        .ch_done           (ch_done),
        .src_addr          (src_addr),
        .src_data          (src_data),
        .mcbsp_slaver_clkx (clkx),
        .mcbsp_slaver_fsx  (fsx),
        .mcbsp_slaver_mosi (mosi),
        .busy              (busy),
        .slot_overrun      (slot_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_val(input logic [10:0] a);
        return {5'h0B, a, 5'h15, ~a};
    endfunction

    function automatic logic [31:0] exp_hdr(input int ch, input logic [10:0] len);
        return {8'hA5, 6'd0, 2'(ch), 5'd0, len};
    endfunction

    // Synchronous ROM: data follows the address by one clock.
    always @(posedge clk) src_data <= rom_val(src_addr);

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ch_done[i]) done_cnt[i]++;
        end
        if (slot_overrun) ovr_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_ch(input int ch, input logic [10:0] base, input logic [10:0] len);
        ch_base[ch*AW +: AW] = base;
        ch_len[ch*AW +: AW]  = len;
    endtask

    task automatic push(input logic [31:0] w, input int gap, input logic [3:0] g);
        exp_t e;
        e.word  = w;
        e.gap   = gap;
        e.grant = g;
        sb.push_back(e);
    endtask

    task automatic push_burst(input int ch, input logic [10:0] base, input logic [10:0] len,
                              input int first_gap);
        logic [3:0]  g;
        logic [10:0] a;
        g = 4'b0001 << ch;
        push(exp_hdr(ch, len), first_gap, g);
        for (int k = 0; k < int'(len); k++) begin
            a = base + 11'(k);
            push(rom_val(a), 4, g);
        end
        push(32'hE0D0_E0D0, 4, g);
    endtask

    // Waits for fsx (bounded), then shifts in 32 bits; slot_start is a one-clock pulse.
    task automatic recv();
        exp_t        e;
        int          waited;
        logic [31:0] w;
        waited = 0;
        w = '0;
        while (fsx !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
            slot_start = 1'b0;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'(waited), 64'(0));
            return;
        end
        e = sb.pop_front();
        chk("fsx_gap", 64'(waited), 64'(e.gap));
        if (waited >= 100) return;
        chk("grant", 64'(ch_grant), 64'(e.grant));
        for (int b = 31; b >= 0; b--) begin
            @(negedge clk);
            w[b] = mosi;
            if (b == 31) chk("fsx_width", 64'(fsx), 64'(0));
        end
        chk("word", 64'(w), 64'(e.word));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({fsx, mosi, ch_grant, ch_done, src_addr, busy, slot_overrun}),
            64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // ch1 alone, len 3; request drop mid-burst is ignored.
        set_ch(1, 11'h010, 11'd3);
        ch_req = 4'b0010;
        push_burst(1, 11'h010, 11'd3, 5);
        slot_start = 1'b1;
        recv();
        ch_req = 4'b0000;
        repeat (4) recv();
        @(negedge clk);
        chk("done_pulse_ch1", 64'(ch_done), 64'(4'b0010));
        repeat (3) @(negedge clk);
        chk("done_cnt_ch1", 64'(done_cnt[1]), 64'(1));
        chk("idle_after_t1", 64'(busy), 64'(0));
        ch_req = 4'b0010;
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || fsx) act++;
        end
        chk("disarmed_no_start", 64'(act), 64'(0));
        ch_req = 4'b0000;

        // All four requesting after reset: ch0..ch3 in order, one-clock ARB gap.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            set_ch(c, 11'(c * 256 + 256), 11'd1);
            push_burst(c, 11'(c * 256 + 256), 11'd1, 5);
        end
        for (int c = 0; c < 4; c++) done_cnt[c] = 0;
        ch_req = 4'b1111;
        slot_start = 1'b1;
        repeat (10) recv();
        ch_req = 4'b0000;
        repeat (2) recv();
        repeat (4) @(negedge clk);
        for (int c = 0; c < 4; c++) chk("done_cnt_rr", 64'(done_cnt[c]), 64'(1));
        chk("idle_after_rr", 64'(busy), 64'(0));

        // ch2 len 0: header followed directly by tail.
        set_ch(2, 11'h123, 11'd0);
        ch_req = 4'b0100;
        push_burst(2, 11'h123, 11'd0, 5);
        slot_start = 1'b1;
        recv();
        ch_req = 4'b0000;
        recv();
        repeat (4) @(negedge clk);
        chk("done_cnt_len0", 64'(done_cnt[2]), 64'(2));

        // ch0 base 0x7FE len 4: address wraps.
        set_ch(0, 11'h7FE, 11'd4);
        ch_req = 4'b0001;
        push_burst(0, 11'h7FE, 11'd4, 5);
        slot_start = 1'b1;
        recv();
        ch_req = 4'b0000;
        repeat (5) recv();
        repeat (4) @(negedge clk);
        chk("no_overrun_yet", 64'(ovr_cnt), 64'(0));

        // Second slot_start mid-burst: one overrun, stream unchanged.
        set_ch(3, 11'h050, 11'd2);
        ch_req = 4'b1000;
        push_burst(3, 11'h050, 11'd2, 5);
        slot_start = 1'b1;
        recv();
        ch_req = 4'b0000;
        slot_start = 1'b1;
        repeat (3) recv();
        repeat (4) @(negedge clk);
        chk("overrun_cnt", 64'(ovr_cnt), 64'(1));
        chk("idle_after_ovr", 64'(busy), 64'(0));

        // Reset at count 20 of the first DATA word.
        set_ch(1, 11'h020, 11'd3);
        ch_req = 4'b0010;
        push_burst(1, 11'h020, 11'd3, 5);
        slot_start = 1'b1;
        recv();
        repeat (21) @(negedge clk);
        chk("busy_before_reset", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("reset_mid_slot", 64'({fsx, mosi, ch_grant, ch_done, src_addr, busy, slot_overrun}),
            64'(0));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        repeat (80) begin
            @(negedge clk);
            if (busy || fsx) act++;
        end
        chk("no_fsx_after_reset", 64'(act), 64'(0));

        // Recovery burst after reset.
        push_burst(1, 11'h020, 11'd3, 5);
        slot_start = 1'b1;
        recv();
        ch_req = 4'b0000;
        repeat (4) recv();
        repeat (4) @(negedge clk);
        chk("idle_at_end", 64'(busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
